race_controller: RTL and testbench
==================================

// Module: race_controller
// PURPOSE
//  N-player race sequencer: IDLE -> COUNTDOWN -> RACE -> RESULTS.
//  Generalises the fixed 2-player light/timer/finish glue into one parametrised block.
//  Owns per-player ms timers, finish detection and finishing order.
//  Sits between game_menu/kb_interface and the draw_*/scoreboard chain in the 65 MHz domain.
// PARAMETERS
//  NUM_PLAYERS      2    number of players/lanes (1..8)
//  POS_WIDTH        32   width of each player position word
//  FINISH_LINE_POS  500  position at which a player is finished (>=)
//  COUNTDOWN_SECS   5    countdown length in seconds before RACE
//  RANK_W           3    width of each rank field (1-based place)
// PORTS
//  clk           in   1                    65 MHz system clock
//  reset         in   1                    synchronous, active-low (0 = reset)
//  ms_tick       in   1                    1-cycle strobe, once per millisecond
//  start_req     in   1                    1-cycle pulse: start race (IDLE only)
//  restart_req   in   1                    1-cycle pulse: abort/return to IDLE
//  throttle      in   NUM_PLAYERS          per-player throttle key level
//  position      in   NUM_PLAYERS*POS_WIDTH  packed positions, player 0 in LSBs
//  state         out  2                    0 IDLE, 1 COUNTDOWN, 2 RACE, 3 RESULTS
//  countdown_sec out  4                    elapsed countdown seconds
//  race_enable   out  NUM_PLAYERS          per-player enable for game_controller
//  finished      out  NUM_PLAYERS          per-player finish flag (sticky)
//  player_time   out  NUM_PLAYERS*22       {sec[21:10], ms[9:0]} per player
//  rank          out  NUM_PLAYERS*RANK_W   place per player, 0 = not placed
//  all_done      out  1                    1 in RESULTS
// BEHAVIOUR
//  - Reset (reset==0 at clk edge): all outputs 0, state=IDLE, internal ms counter 0.
//  - IDLE: start_req -> COUNTDOWN next edge. Timers, ranks, flags and countdown are cleared.
//    If restart_req and start_req are both high, restart wins and state stays IDLE.
//  - COUNTDOWN: internal ms counter 0..999 advances on ms_tick.
//    On the 999->0 wrap, countdown_sec increments.
//    On the edge where countdown_sec becomes COUNTDOWN_SECS, state -> RACE.
//  - RACE: race_enable[i] = (state==RACE) & ~finished[i]; this output is combinational.
//    player_time[i] advances on ms_tick while race_enable[i] is high.
//    ms wraps 999->0 and carries into sec; sec saturates at 4095 with ms held at 999.
//  - Finish: compare position[i] >= FINISH_LINE_POS, unsigned, during RACE.
//    finished[i] sets on the next edge.
//    An ms_tick in the detecting cycle is not counted, so the timer freezes at its pre-cycle value.
//  - Ranking: rank[i] = (finishers in earlier cycles) + (same-cycle finishers with lower index) + 1.
//    Same-cycle ties are broken by player index, lower index gets the better place.
//  - When all finished bits are 1, state -> RESULTS on the next edge; all_done=1.
//    Timers, ranks and finished hold their values.
//  - restart_req in COUNTDOWN/RACE/RESULTS: state -> IDLE next edge, all outputs cleared.
//    This is the mid-race abort path.
//  - start_req outside IDLE is ignored.
//  - No latency on state-derived outputs beyond one register stage.
// CONFIGURATION
//  FALSE_START_EN defined: a throttle[i]==1 sample in COUNTDOWN disqualifies player i.
//    finished[i]=1, player_time[i]=22'h3FFFFF, rank[i]=0 (never placed).
//    The player counts toward all_done but not toward placings.
//    race_enable[i] stays 0 for the whole race.
//  FALSE_START_EN undefined: throttle is ignored and all players start on RACE entry.
// TESTING
//  T1 reset=0 for 2 cycles -> state=0, every output 0.
//     Release reset, then start_req -> state=1 next edge.
//  T2 NUM_PLAYERS=2, COUNTDOWN_SECS=5: after 5000 ms_ticks -> state=2, race_enable=2'b11.
//     At 4999 ticks state is still 1.
//  T3 Raise pos0 to 500 at 1234 ms race time and pos1 to 600 at 2000 ms.
//     Expect time0=sec1/ms234, rank0=1, time1=sec2/ms0, rank1=2, state=3, all_done=1.
//  T4 Both positions cross 500 in the same cycle -> rank0=1, rank1=2, identical times.
//  T5 restart_req mid-RACE at 300 ms -> state=0 next edge, timers/ranks/finished all 0.
//     start_req and restart_req together in IDLE -> stays 0.
//  T6 (FALSE_START_EN) throttle[1]=1 during COUNTDOWN.
//     Expect finished[1]=1, time1=22'h3FFFFF, rank1=0.
//     Player 0 finishing -> rank0=1, state=3.

Source files
------------

// File: rtl/race_controller.sv
// N-player race sequencer: IDLE -> COUNTDOWN -> RACE -> RESULTS with per-player ms timers and placings.
// Optional feature macro: FALSE_START_EN (throttle during countdown disqualifies that player).
module race_controller #(
  parameter int unsigned NUM_PLAYERS     = 2,
  parameter int unsigned POS_WIDTH       = 32,
  parameter int unsigned FINISH_LINE_POS = 500,
  parameter int unsigned COUNTDOWN_SECS  = 5,
  parameter int unsigned RANK_W          = 3
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_ms_tick,
  input  logic                              i_start_req,
  input  logic                              i_restart_req,
  input  logic [NUM_PLAYERS-1:0]            i_throttle,
  input  logic [NUM_PLAYERS*POS_WIDTH-1:0]  i_position,
  output logic [1:0]                        o_state,
  output logic [3:0]                        o_countdown_sec,
  output logic [NUM_PLAYERS-1:0]            o_race_enable,
  output logic [NUM_PLAYERS-1:0]            o_finished,
  output logic [NUM_PLAYERS*22-1:0]         o_player_time,
  output logic [NUM_PLAYERS*RANK_W-1:0]     o_rank,
  output logic                              o_all_done
);

  localparam int unsigned TIME_W  = 22;
  localparam int unsigned PLACE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COUNTDOWN = 2'd1,
    S_RACE      = 2'd2,
    S_RESULTS   = 2'd3
  } state_t;

  state_t                                r_state;
  state_t                                w_next;
  logic                                  r_all_done;
  logic [9:0]                            r_ms_cnt;
  logic [3:0]                            r_cd_sec;
  logic [NUM_PLAYERS-1:0]                r_finished;
  logic [NUM_PLAYERS-1:0][TIME_W-1:0]    r_time;
  logic [NUM_PLAYERS-1:0][RANK_W-1:0]    r_rank;
  logic [PLACE_W-1:0]                    r_placed;

  logic                                  w_cd_wrap;
  logic                                  w_clear;
  logic [NUM_PLAYERS-1:0]                w_race_en;
  logic [NUM_PLAYERS-1:0]                w_cross;
  logic [NUM_PLAYERS-1:0][RANK_W-1:0]    w_rank_new;
  logic [PLACE_W-1:0]                    w_placed_next;

  assign w_cd_wrap = i_ms_tick && (r_ms_cnt == 10'd999);
  assign w_clear   = (r_state == S_IDLE) || i_restart_req;
  assign w_race_en = {NUM_PLAYERS{r_state == S_RACE}} & ~r_finished;

  // {sec, ms} increment; sec saturates at 4095 with ms pinned at 999
  function automatic logic [TIME_W-1:0] f_time_inc(input logic [TIME_W-1:0] t);
    logic [11:0] sec;
    logic [9:0]  ms;
    sec = t[21:10];
    ms  = t[9:0];
    if (sec == 12'hFFF && ms == 10'd999) return t;
    else if (ms == 10'd999)              return {sec + 12'd1, 10'd0};
    else                                 return {sec, ms + 10'd1};
  endfunction

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (i_start_req && !i_restart_req) w_next = S_COUNTDOWN;
      S_COUNTDOWN: if (i_restart_req) w_next = S_IDLE;
                   else if (w_cd_wrap && r_cd_sec == 4'(COUNTDOWN_SECS - 1)) w_next = S_RACE;
      S_RACE:      if (i_restart_req) w_next = S_IDLE;
                   else if (&r_finished) w_next = S_RESULTS;
      S_RESULTS:   if (i_restart_req) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_all_done <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_all_done <= (w_next == S_RESULTS);
    end
  end

  // Same-cycle finishers are placed in player-index order
  always_comb begin
    w_cross       = '0;
    w_rank_new    = '0;
    w_placed_next = r_placed;
    for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
      w_cross[i]    = (r_state == S_RACE) && !r_finished[i] &&
                      (i_position[i*POS_WIDTH +: POS_WIDTH] >= POS_WIDTH'(FINISH_LINE_POS));
      w_rank_new[i] = RANK_W'(w_placed_next + PLACE_W'(1));
      if (w_cross[i]) w_placed_next = w_placed_next + PLACE_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset || w_clear) begin
      r_ms_cnt   <= '0;
      r_cd_sec   <= '0;
      r_finished <= '0;
      r_time     <= '0;
      r_rank     <= '0;
      r_placed   <= '0;
    end else begin
      if (r_state == S_COUNTDOWN) begin
        if (i_ms_tick) begin
          r_ms_cnt <= w_cd_wrap ? 10'd0 : r_ms_cnt + 10'd1;
          if (w_cd_wrap) r_cd_sec <= r_cd_sec + 4'd1;
        end
`ifdef FALSE_START_EN
        for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
          if (i_throttle[i]) begin
            r_finished[i] <= 1'b1;
            r_time[i]     <= '1;
            r_rank[i]     <= '0;
          end
        end
`endif
      end
      if (r_state == S_RACE) begin
        r_placed <= w_placed_next;
        // A tick in the detecting cycle is dropped so the time freezes at its pre-cycle value
        for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
          if (w_cross[i]) begin
            r_finished[i] <= 1'b1;
            r_rank[i]     <= w_rank_new[i];
          end else if (i_ms_tick && w_race_en[i]) begin
            r_time[i] <= f_time_inc(r_time[i]);
          end
        end
      end
    end
  end

`ifndef FALSE_START_EN
  logic w_unused_throttle;
  assign w_unused_throttle = ^i_throttle;
`endif

  assign o_state         = r_state;
  assign o_countdown_sec = r_cd_sec;
  assign o_race_enable   = w_race_en;
  assign o_finished      = r_finished;
  assign o_player_time   = r_time;
  assign o_rank          = r_rank;
  assign o_all_done      = r_all_done;

endmodule

// File: tb/tb_race_controller.sv
// Scoreboard bench for race_controller: driver queues expectations, a negedge monitor compares them.
// Exercises the FALSE_START_EN path when that macro is defined for the build.
module tb_race_controller;

  localparam int unsigned NP = 2;
  localparam int unsigned PW = 32;
  localparam int unsigned RW = 3;

  localparam int F_STATE = 0, F_CDSEC = 1, F_EN = 2, F_FIN = 3, F_T0 = 4, F_T1 = 5,
                 F_R0 = 6, F_R1 = 7, F_DONE = 8, F_ZERO = 9;

  logic                clk = 1'b0;
  logic                reset;
  logic                ms_tick;
  logic                start_req;
  logic                restart_req;
  logic [NP-1:0]       throttle;
  logic [NP*PW-1:0]    position;
  logic [1:0]          state;
  logic [3:0]          countdown_sec;
  logic [NP-1:0]       race_enable;
  logic [NP-1:0]       finished;
  logic [NP*22-1:0]    player_time;
  logic [NP*RW-1:0]    rank;
  logic                all_done;

  always #5 clk = ~clk;

  race_controller #(
    .NUM_PLAYERS(NP), .POS_WIDTH(PW), .FINISH_LINE_POS(500), .COUNTDOWN_SECS(5), .RANK_W(RW)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_ms_tick(ms_tick), .i_start_req(start_req),
    .i_restart_req(restart_req), .i_throttle(throttle), .i_position(position),
    .o_state(state), .o_countdown_sec(countdown_sec), .o_race_enable(race_enable),
    .o_finished(finished), .o_player_time(player_time), .o_rank(rank), .o_all_done(all_done)
  );

  typedef struct {
    string       name;
    int          field;
    logic [63:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [63:0] sample(input int field);
    case (field)
      F_STATE: return 64'(state);
      F_CDSEC: return 64'(countdown_sec);
      F_EN:    return 64'(race_enable);
      F_FIN:   return 64'(finished);
      F_T0:    return 64'(player_time[21:0]);
      F_T1:    return 64'(player_time[43:22]);
      F_R0:    return 64'(rank[RW-1:0]);
      F_R1:    return 64'(rank[2*RW-1:RW]);
      F_DONE:  return 64'(all_done);
      default: return 64'({state, countdown_sec, race_enable, finished, player_time, rank, all_done});
    endcase
  endfunction

  function automatic logic [63:0] tval(input int sec, input int ms);
    return 64'({12'(sec), 10'(ms)});
  endfunction

  task automatic expect_val(input string name, input int field, input logic [63:0] v);
    exp_t e;
    e.name  = name;
    e.field = field;
    e.exp   = v;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are stable at negedge, drain all queued expectations there
  initial begin
    exp_t        e;
    logic [63:0] act;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = sample(e.field);
        n_cmp++;
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic step(input logic tick);
    ms_tick = tick;
    @(posedge clk);
    #1;
    ms_tick     = 1'b0;
    start_req   = 1'b0;
    restart_req = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1'b1);
  endtask

  task automatic start_to_race(input string tag);
    start_req = 1'b1;
    step(1'b0);
    expect_val({tag, "_start_state"}, F_STATE, 64'd1);
    ticks(4999);
    expect_val({tag, "_cd4999_state"}, F_STATE, 64'd1);
    expect_val({tag, "_cd4999_sec"}, F_CDSEC, 64'd4);
    ticks(1);
    expect_val({tag, "_race_state"}, F_STATE, 64'd2);
    expect_val({tag, "_race_sec"}, F_CDSEC, 64'd5);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; ms_tick = 1'b0; start_req = 1'b0; restart_req = 1'b0;
    throttle = '0; position = '0;

    // T1: reset
    step(1'b0);
    step(1'b0);
    expect_val("t1_reset_zero", F_ZERO, 64'd0);
    reset = 1'b1;
    step(1'b0);
    expect_val("t1_idle_zero", F_ZERO, 64'd0);

    // T2: countdown length, all players enabled on entry
    start_to_race("t2");
    expect_val("t2_enable", F_EN, 64'd3);

    // T3: staggered finishes
    ticks(1234);
    position[PW-1:0] = 32'd500;
    step(1'b1);
    expect_val("t3_fin0", F_FIN, 64'd1);
    expect_val("t3_time0", F_T0, tval(1, 234));
    expect_val("t3_rank0", F_R0, 64'd1);
    expect_val("t3_enable", F_EN, 64'd2);
    ticks(765);
    position[2*PW-1:PW] = 32'd600;
    step(1'b1);
    expect_val("t3_time1", F_T1, tval(2, 0));
    expect_val("t3_rank1", F_R1, 64'd2);
    expect_val("t3_state_race", F_STATE, 64'd2);
    expect_val("t3_not_done", F_DONE, 64'd0);
    step(1'b0);
    expect_val("t3_state_results", F_STATE, 64'd3);
    expect_val("t3_all_done", F_DONE, 64'd1);
    expect_val("t3_time0_hold", F_T0, tval(1, 234));

    // T4: same-cycle tie, throttle ignored unless false-start is built in
    restart_req = 1'b1;
    position = '0;
    step(1'b0);
    expect_val("t4_restart_zero", F_ZERO, 64'd0);
`ifndef FALSE_START_EN
    throttle = 2'b11;
`endif
    start_to_race("t4");
    expect_val("t4_enable", F_EN, 64'd3);
    throttle = '0;
    ticks(50);
    position = {32'd700, 32'd700};
    step(1'b0);
    expect_val("t4_fin", F_FIN, 64'd3);
    expect_val("t4_rank0", F_R0, 64'd1);
    expect_val("t4_rank1", F_R1, 64'd2);
    expect_val("t4_time0", F_T0, tval(0, 50));
    expect_val("t4_time1", F_T1, tval(0, 50));
    step(1'b0);
    expect_val("t4_state_results", F_STATE, 64'd3);

    // T5: mid-race abort, restart priority, start ignored outside IDLE
    restart_req = 1'b1;
    position = '0;
    step(1'b0);
    start_to_race("t5");
    ticks(300);
    expect_val("t5_time0", F_T0, tval(0, 300));
    expect_val("t5_time1", F_T1, tval(0, 300));
    restart_req = 1'b1;
    step(1'b0);
    expect_val("t5_abort_zero", F_ZERO, 64'd0);
    start_req = 1'b1;
    restart_req = 1'b1;
    step(1'b0);
    expect_val("t5_both_state", F_STATE, 64'd0);
    start_req = 1'b1;
    step(1'b0);
    start_req = 1'b1;
    step(1'b0);
    expect_val("t5_start_ignored", F_STATE, 64'd1);
    restart_req = 1'b1;
    step(1'b0);
    expect_val("t5_cd_abort", F_STATE, 64'd0);

`ifdef FALSE_START_EN
    // T6: false start disqualifies player 1
    start_req = 1'b1;
    step(1'b0);
    for (int k = 0; k < 4999; k++) begin
      throttle = (k == 100) ? 2'b10 : 2'b00;
      step(1'b1);
    end
    throttle = '0;
    expect_val("t6_fin_dq", F_FIN, 64'd2);
    expect_val("t6_time1", F_T1, 64'h3FFFFF);
    expect_val("t6_rank1", F_R1, 64'd0);
    ticks(1);
    expect_val("t6_race_state", F_STATE, 64'd2);
    expect_val("t6_enable", F_EN, 64'd1);
    ticks(10);
    position[PW-1:0] = 32'd500;
    step(1'b0);
    expect_val("t6_fin", F_FIN, 64'd3);
    expect_val("t6_rank0", F_R0, 64'd1);
    expect_val("t6_time0", F_T0, tval(0, 10));
    expect_val("t6_rank1_hold", F_R1, 64'd0);
    step(1'b0);
    expect_val("t6_state_results", F_STATE, 64'd3);
    expect_val("t6_all_done", F_DONE, 64'd1);
`endif

    repeat (5) @(negedge clk);
    if (exp_q.size() > 0) begin
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
      n_bad += exp_q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
